uart_rx_ext: RTL and testbench

//  Parametrised UART receiver, the successor to the fixed 8N1 receiver. Adds configurable data width,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sampler.sv | 34 +++
 rtl/uart_rx_ext.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_ext.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: the FSM state encoding
// and the parity-mode constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int PARITY_MODE_EVEN = 0;
   localparam int PARITY_MODE_ODD  = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Pad-side front end of the receiver: two-flop synchroniser, then a three-tap history
// advanced on every oversampling tick and reduced to a majority-voted bit.
module uart_rx_sampler (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   input  logic s_tick,
   output logic rxs,
   output logic maj
);

   logic       sync_a;
   logic       sync_b;
   logic [2:0] taps;

   // Idle line is high, so every stage resets to 1 to avoid a false start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         taps   <= 3'b111;
      end else begin
         sync_a <= rx;
         sync_b <= sync_a;
         if (s_tick) begin
            taps <= {taps[1:0], sync_b};
         end
      end
   end

   assign rxs = sync_b;
   assign maj = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: tick-driven frame FSM with majority-voted sampling,
// parity/framing/break detection and a one-cycle done strobe.
//
//   state  | meaning
//   IDLE   | line idle, waiting for synchronised line low
//   START  | half-bit wait, rejects start glitches
//   DATA   | sampling DBIT data bits, LSB first
//   PARITY | sampling the parity bit
//   STOP   | waiting SB_TICK ticks, then stop decision and result update
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = PARITY_MODE_EVEN,
   parameter int OVS        = 16,
   parameter int SB_TICK    = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_rx,
   input  logic            i_s_tick,
   output logic [DBIT-1:0] o_rx,
   output logic            o_rx_done,
   output logic            o_parity_err,
   output logic            o_frame_err,
   output logic            o_break,
   output logic            o_busy
);

   localparam int SW = $clog2(max_int(OVS, SB_TICK));
   localparam int NW = $clog2(DBIT);
   localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic HAS_PAR = (PARITY_EN != 0);
   localparam logic ODD     = (PARITY_ODD == PARITY_MODE_ODD);

   logic rxs;
   logic maj;

   uart_rx_sampler u_sampler (
      .clk    (i_clk),
      .reset  (i_reset),
      .rx     (i_rx),
      .s_tick (i_s_tick),
      .rxs    (rxs),
      .maj    (maj)
   );

   uart_state_t     state, state_n;
   logic [SW-1:0]   s, s_n;
   logic [NW-1:0]   n, n_n;
   logic [DBIT-1:0] word, word_n;
   logic            psample, psample_n;
   logic            perr, perr_n;
   logic [DBIT-1:0] rx_n;
   logic            done_n, perr_out_n, ferr_n, brk_n;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         word         <= '0;
         psample      <= 1'b0;
         perr         <= 1'b0;
         o_rx         <= '0;
         o_rx_done    <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
      end else begin
         state        <= state_n;
         s            <= s_n;
         n            <= n_n;
         word         <= word_n;
         psample      <= psample_n;
         perr         <= perr_n;
         o_rx         <= rx_n;
         o_rx_done    <= done_n;
         o_parity_err <= perr_out_n;
         o_frame_err  <= ferr_n;
         o_break      <= brk_n;
      end
   end

   always_comb begin
      state_n    = state;
      s_n        = s;
      n_n        = n;
      word_n     = word;
      psample_n  = psample;
      perr_n     = perr;
      rx_n       = o_rx;
      done_n     = 1'b0;
      perr_out_n = o_parity_err;
      ferr_n     = o_frame_err;
      brk_n      = o_break;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_n = START;
               s_n     = '0;
            end
         end
         START: begin
            if (i_s_tick) begin
               if (s == S_MID) begin
                  if (maj) begin
                     state_n = IDLE;
                  end else begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (s == S_BIT) begin
                  s_n    = '0;
                  word_n = {maj, word[DBIT-1:1]};
                  if (n == N_LAST) begin
                     state_n = HAS_PAR ? PARITY : STOP;
                  end else begin
                     n_n = n + 1'b1;
                  end
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
         PARITY: begin
            if (i_s_tick) begin
               if (s == S_BIT) begin
                  psample_n = maj;
                  perr_n    = maj ^ (^word) ^ ODD;
                  s_n       = '0;
                  state_n   = STOP;
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (s == S_STOP) begin
                  state_n    = IDLE;
                  rx_n       = word;
                  done_n     = 1'b1;
                  perr_out_n = HAS_PAR & perr;
                  ferr_n     = ~maj;
                  // Break: everything low, including the parity bit when present.
                  brk_n      = ~maj & (word == '0) & (HAS_PAR ? ~psample : 1'b1);
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: three configurations (8N1, 8E1, 5N2) driven with
// directed and random frames; expected results come from the frame contents alone.
module tb_uart_rx_ext;

   logic clk = 1'b0;
   logic reset, s_tick;
   logic rx0, rx1, rx2;
   logic [7:0] d0, d1;
   logic [4:0] d2;
   logic done0, done1, done2, pe0, pe1, pe2, fe0, fe1, fe2, br0, br1, br2;
   logic busy0, busy1, busy2;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   exp_t q[3][$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   done_cnt[3] = '{0, 0, 0};
   logic prev_done[3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   uart_rx_ext #(.DBIT(8), .PARITY_EN(0), .PARITY_ODD(0), .OVS(16), .SB_TICK(16)) u0 (
      .i_clk(clk), .i_reset(reset), .i_rx(rx0), .i_s_tick(s_tick), .o_rx(d0), .o_rx_done(done0),
      .o_parity_err(pe0), .o_frame_err(fe0), .o_break(br0), .o_busy(busy0));

   uart_rx_ext #(.DBIT(8), .PARITY_EN(1), .PARITY_ODD(0), .OVS(16), .SB_TICK(16)) u1 (
      .i_clk(clk), .i_reset(reset), .i_rx(rx1), .i_s_tick(s_tick), .o_rx(d1), .o_rx_done(done1),
      .o_parity_err(pe1), .o_frame_err(fe1), .o_break(br1), .o_busy(busy1));

   uart_rx_ext #(.DBIT(5), .PARITY_EN(0), .PARITY_ODD(0), .OVS(16), .SB_TICK(32)) u2 (
      .i_clk(clk), .i_reset(reset), .i_rx(rx2), .i_s_tick(s_tick), .o_rx(d2), .o_rx_done(done2),
      .o_parity_err(pe2), .o_frame_err(fe2), .o_break(br2), .o_busy(busy2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic mon(input int k, input logic done, input logic [8:0] data,
                      input logic pe, input logic fe, input logic br);
      exp_t e;
      if (prev_done[k]) check($sformatf("u%0d done width", k), 32'(done), 0);
      prev_done[k] = done;
      if (done) begin
         done_cnt[k]++;
         check($sformatf("u%0d frame expected", k), 32'(q[k].size() > 0), 1);
         if (q[k].size() > 0) begin
            e = q[k].pop_front();
            check($sformatf("u%0d data", k), 32'(data), 32'(e.data));
            check($sformatf("u%0d parity_err", k), 32'(pe), 32'(e.perr));
            check($sformatf("u%0d frame_err", k), 32'(fe), 32'(e.ferr));
            check($sformatf("u%0d break", k), 32'(br), 32'(e.brk));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, done0, {1'b0, d0}, pe0, fe0, br0);
      mon(1, done1, {1'b0, d1}, pe1, fe1, br1);
      mon(2, done2, {4'b0, d2}, pe2, fe2, br2);
   end

   task automatic step();
      @(negedge clk) s_tick = 1'b1;
      @(negedge clk) s_tick = 1'b0;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic set_line(input int k, input logic v);
      case (k)
         0: rx0 = v;
         1: rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   // One bit time of 16 ticks; a glitch inverts the line for one tick in mid-bit.
   task automatic bit_out(input int k, input logic v, input bit glitch);
      set_line(k, v);
      if (glitch) begin
         steps(6);
         set_line(k, ~v);
         step();
         set_line(k, v);
         steps(9);
      end else begin
         steps(16);
      end
   endtask

   task automatic send_frame(input int k, input int dbit, input bit par_en, input bit odd,
                             input logic [8:0] data, input logic pbit, input int nstop,
                             input logic stop_ok, input int glitch_bit);
      exp_t       e;
      logic [8:0] dm;
      int         ones;
      dm     = data & 9'((1 << dbit) - 1);
      ones   = $countones(dm);
      e.data = dm;
      e.perr = par_en ? (pbit ^ ones[0] ^ odd) : 1'b0;
      e.ferr = !stop_ok;
      e.brk  = !stop_ok && (dm == 0) && (!par_en || !pbit);
      q[k].push_back(e);
      bit_out(k, 1'b0, 1'b0);
      for (int i = 0; i < dbit; i++) bit_out(k, dm[i], i == glitch_bit);
      if (par_en) bit_out(k, pbit, 1'b0);
      if (stop_ok) begin
         set_line(k, 1'b1);
         steps(16 * nstop);
      end else begin
         // Low through the stop sample only, so the line is back high before a restart is judged.
         set_line(k, 1'b0);
         steps(16 * (nstop - 1) + 12);
         set_line(k, 1'b1);
         steps(4);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      logic [8:0] rd;
      logic ok;
      int   gb;
      reset = 1'b1; s_tick = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      repeat (4) @(negedge clk);
      check("reset u0 outputs", 32'({busy0, done0, pe0, fe0, br0, d0}), 0);
      check("reset u1 outputs", 32'({busy1, done1, pe1, fe1, br1, d1}), 0);
      check("reset u2 outputs", 32'({busy2, done2, pe2, fe2, br2, d2}), 0);
      @(negedge clk) reset = 1'b0;
      steps(4);

      send_frame(0, 8, 0, 0, 9'hA5, 1'b0, 1, 1'b1, -1);
      steps(4);
      check("u0 idle after A5", 32'(busy0), 0);

      base = done_cnt[0];
      set_line(0, 1'b0);
      steps(3);
      set_line(0, 1'b1);
      steps(20);
      check("u0 start glitch no done", 32'(done_cnt[0] - base), 0);
      check("u0 start glitch idle", 32'(busy0), 0);
      check("u0 start glitch data held", 32'(d0), 32'h A5);

      send_frame(0, 8, 0, 0, 9'h5C, 1'b0, 1, 1'b1, 3);
      steps(4);
      send_frame(0, 8, 0, 0, 9'h3C, 1'b0, 1, 1'b0, -1);
      steps(12);
      check("u0 idle after bad stop", 32'(busy0), 0);

      base = done_cnt[0];
      q[0].push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
      q[0].push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
      set_line(0, 1'b0);
      for (int i = 0; i < 400 && (done_cnt[0] - base) < 2; i++) step();
      set_line(0, 1'b1);
      steps(20);
      check("u0 break frame count", 32'(done_cnt[0] - base), 2);
      check("u0 idle after break", 32'(busy0), 0);

      for (int i = 0; i < 8; i++) begin
         rd = 9'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         send_frame(0, 8, 0, 0, rd, 1'b0, 1, ok, gb);
         steps(ok ? int'($urandom_range(0, 6)) : 20);
      end

      send_frame(0, 8, 0, 0, 9'hC3, 1'b0, 1, 1'b1, -1);
      steps(4);
      base = done_cnt[0];
      bit_out(0, 1'b0, 1'b0);
      bit_out(0, 1'b0, 1'b0);
      bit_out(0, 1'b1, 1'b0);
      bit_out(0, 1'b1, 1'b0);
      set_line(0, 1'b0);
      steps(5);
      check("u0 busy mid data", 32'(busy0), 1);
      @(negedge clk);
      s_tick = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
      check("u0 reset mid frame outputs", 32'({busy0, done0, pe0, fe0, br0, d0}), 0);
      reset = 1'b0;
      set_line(0, 1'b1);
      steps(20);
      check("u0 no done from aborted frame", 32'(done_cnt[0] - base), 0);
      send_frame(0, 8, 0, 0, 9'h5A, 1'b0, 1, 1'b1, -1);
      steps(4);

      send_frame(1, 8, 1, 0, 9'h07, 1'b1, 1, 1'b1, -1);
      send_frame(1, 8, 1, 0, 9'h07, 1'b0, 1, 1'b1, -1);
      for (int i = 0; i < 6; i++) begin
         send_frame(1, 8, 1, 0, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1, 1'b1, -1);
         steps($urandom_range(0, 4));
      end

      send_frame(2, 5, 0, 0, 9'h15, 1'b0, 2, 1'b1, -1);
      send_frame(2, 5, 0, 0, 9'h0A, 1'b0, 2, 1'b1, -1);
      for (int i = 0; i < 5; i++) begin
         send_frame(2, 5, 0, 0, 9'($urandom_range(0, 31)), 1'b0, 2, 1'b1, -1);
         steps($urandom_range(0, 3));
      end
      steps(30);

      check("u0 scoreboard drained", 32'(q[0].size()), 0);
      check("u1 scoreboard drained", 32'(q[1].size()), 0);
      check("u2 scoreboard drained", 32'(q[2].size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
